// File: rtl/nrzi_unstuff_rx.sv
// nrzi_unstuff_rx: NRZI decode, bit unstuffing and WIDTH-bit deserialisation for the USB receive path.
// Optional build macro NRZI_STUFF_CHECK_EN: flag a stuff violation on stuff_err and drop the frame.
module nrzi_unstuff_rx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STUFF_LEN  = 6,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             s_in,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             rx_idle,
    output logic             end_pulse,
    output logic             align_err,
    output logic             overrun,
    output logic             stuff_err
);

    localparam int unsigned BIT_W  = $clog2(WIDTH);
    localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;

    logic [1:0]        r_state,     w_state_nxt;
    logic              r_prev,      w_prev_nxt;
    logic [ONES_W-1:0] r_ones,      w_ones_nxt;
    logic [BIT_W-1:0]  r_bit_cnt,   w_bit_nxt;
    logic [WIDTH-1:0]  r_shift,     w_shift_nxt;
    logic [WIDTH-1:0]  r_out_data,  w_data_nxt;
    logic              r_out_valid, w_valid_nxt;
    logic              r_rx_idle;
    logic              r_end,       w_end_nxt;
    logic              r_align,     w_align_nxt;
    logic              r_ovr,       w_ovr_nxt;
    logic              r_stuff,     w_stuff_nxt;
    logic              w_d;
    logic              w_accept;
    logic [WIDTH-1:0]  w_word;

    // A line level held across a bit time decodes as 1, a transition as 0
    assign w_d = ~(r_prev ^ s_in);

    always_comb begin
        w_state_nxt        = r_state;
        w_prev_nxt         = s_in;
        w_ones_nxt         = r_ones;
        w_bit_nxt          = r_bit_cnt;
        w_shift_nxt        = r_shift;
        w_data_nxt         = r_out_data;
        w_valid_nxt        = r_out_valid & ~out_ready;
        w_end_nxt          = 1'b0;
        w_align_nxt        = 1'b0;
        w_ovr_nxt          = 1'b0;
        w_stuff_nxt        = 1'b0;
        w_accept           = 1'b0;
        w_word             = r_shift;
        w_word[r_bit_cnt]  = w_d;

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_prev_nxt  = IDLE_LEVEL;
            w_ones_nxt  = '0;
            w_bit_nxt   = '0;
            w_shift_nxt = '0;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    w_state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    if (stop) begin
                        w_state_nxt = S_IDLE;
                        w_end_nxt   = 1'b1;
                        w_align_nxt = (r_bit_cnt != '0);
                        w_prev_nxt  = IDLE_LEVEL;
                        w_ones_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_shift_nxt = '0;
                    end else if (!w_d) begin
                        w_accept   = (r_ones != ONES_MAX);
                        w_ones_nxt = '0;
                    end else if (r_ones != ONES_MAX) begin
                        w_accept   = 1'b1;
                        w_ones_nxt = r_ones + ONES_W'(1);
                    end else begin
`ifdef NRZI_STUFF_CHECK_EN
                        w_stuff_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                        w_prev_nxt  = IDLE_LEVEL;
                        w_ones_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_shift_nxt = '0;
`else
                        // Violating 1 kept as data; ones_cnt stays saturated so the next 0 is dropped
                        w_accept = 1'b1;
`endif
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        if (w_accept) begin
            if (r_bit_cnt == LAST_BIT) begin
                w_bit_nxt   = '0;
                w_shift_nxt = '0;
                if (!r_out_valid || out_ready) begin
                    w_data_nxt  = w_word;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_ovr_nxt = 1'b1;
                end
            end else begin
                w_bit_nxt   = r_bit_cnt + BIT_W'(1);
                w_shift_nxt = w_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_prev      <= IDLE_LEVEL;
            r_ones      <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_rx_idle   <= 1'b1;
            r_end       <= 1'b0;
            r_align     <= 1'b0;
            r_ovr       <= 1'b0;
            r_stuff     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_ones      <= w_ones_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_rx_idle   <= (w_state_nxt == S_IDLE);
            r_end       <= w_end_nxt;
            r_align     <= w_align_nxt;
            r_ovr       <= w_ovr_nxt;
            r_stuff     <= w_stuff_nxt;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign rx_idle   = r_rx_idle;
    assign end_pulse = r_end;
    assign align_err = r_align;
    assign overrun   = r_ovr;
    assign stuff_err = r_stuff;

endmodule

// File: tb/tb_nrzi_unstuff_rx.sv
// Scoreboard bench for nrzi_unstuff_rx: payload bits are stuffed and NRZI-encoded by the bench,
// expected words/end events are queued and a negedge monitor checks them as the DUT presents them.
module tb_nrzi_unstuff_rx;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned STUFF_LEN = 6;

    logic             clk;
    logic             rst_n;
    logic             abort;
    logic             s_in;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             rx_idle;
    logic             end_pulse;
    logic             align_err;
    logic             overrun;
    logic             stuff_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] exp_q[$];
    bit               end_q[$];
    int               ovr_seen   = 0;
    int               stuff_seen = 0;
    int               ovr_exp    = 0;
    int               stuff_exp  = 0;

    // Encoder / reference model state
    bit line;
    int ones;
    bit part[$];
    bit hold_mode;
    bit model_held;
    bit rand_ready;
    int lo_run;

    nrzi_unstuff_rx #(.WIDTH(WIDTH), .STUFF_LEN(STUFF_LEN), .IDLE_LEVEL(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .s_in      (s_in),
        .start     (start),
        .stop      (stop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rx_idle   (rx_idle),
        .end_pulse (end_pulse),
        .align_err (align_err),
        .overrun   (overrun),
        .stuff_err (stuff_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d words still expected", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: consume a word on each handshake and an end event on each end_pulse
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL word_unexpected: got %0h, required no word", out_data);
                end else begin
                    check("word", out_data, exp_q.pop_front());
                end
            end
            if (end_pulse) begin
                if (end_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL end_unexpected: got end_pulse=1, required 0");
                end else begin
                    check("align_err", align_err, end_q.pop_front());
                end
            end else if (align_err) begin
                n_tests++;
                n_fail++;
                $display("FAIL align_without_end: got align_err=1, required 0");
            end
            if (overrun)   ovr_seen++;
            if (stuff_err) stuff_seen++;
        end
    end

    task automatic cyc();
        if (rand_ready) begin
            if (lo_run >= 2 || $urandom_range(0, 3) != 0) begin
                out_ready = 1'b1;
                lo_run    = 0;
            end else begin
                out_ready = 1'b0;
                lo_run++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Put one decoded bit on the line: 1 keeps the level, 0 toggles it
    task automatic drive_raw(input bit d);
        if (!d) line = ~line;
        s_in = line;
        cyc();
    endtask

    task automatic model_bit(input bit b);
        logic [WIDTH-1:0] w;
        part.push_back(b);
        if (part.size() == WIDTH) begin
            for (int i = 0; i < WIDTH; i++) w[i] = part[i];
            part.delete();
            if (hold_mode && model_held) begin
                ovr_exp++;
            end else begin
                exp_q.push_back(w);
                model_held = hold_mode;
            end
        end
    endtask

    task automatic send_bit(input bit b);
        drive_raw(b);
        model_bit(b);
        if (b) ones++;
        else   ones = 0;
        if (ones == STUFF_LEN) begin
            drive_raw(1'b0);
            ones = 0;
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
    endtask

    task automatic frame_start();
        line  = 1'b1;
        s_in  = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        ones = 0;
        part.delete();
    endtask

    task automatic frame_stop();
        s_in = 1'b1;
        stop = 1'b1;
        end_q.push_back(part.size() != 0);
        part.delete();
        cyc();
        stop = 1'b0;
        line = 1'b1;
        ones = 0;
    endtask

    task automatic frame_abort();
        s_in  = 1'b1;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        exp_q.delete();
        part.delete();
        model_held = 1'b0;
        line = 1'b1;
        ones = 0;
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        rst_n = 1'b0; abort = 1'b0; s_in = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
        line = 1'b1; ones = 0; hold_mode = 1'b0; model_held = 1'b0; rand_ready = 1'b0; lo_run = 0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check("rst_rx_idle", rx_idle, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_pulses", {end_pulse, align_err, overrun, stuff_err}, 0);

        // Alternating line after idle-high decodes to all zeros
        frame_start();
        check("armed_not_idle", rx_idle, 0);
        exp_q.push_back(8'h00);
        for (int i = 0; i < 8; i++) begin
            s_in = (i % 2 == 1);
            cyc();
            if (i == 6) check("t1_valid_before", out_valid, 0);
        end
        line = 1'b1;
        check("t1_valid_after", out_valid, 1);
        check("t1_data", out_data, 8'h00);
        frame_stop();

        // Six ones, stuffed zero, then 0,1
        frame_start();
        exp_q.push_back(8'hBF);
        for (int i = 0; i < 6; i++) drive_raw(1'b1);
        drive_raw(1'b0);
        drive_raw(1'b0);
        drive_raw(1'b1);
        check("t2_data", out_data, 8'hBF);
        check("t2_valid", out_valid, 1);
        frame_stop();

        // Seven consecutive decoded ones
        frame_start();
        for (int i = 0; i < 7; i++) drive_raw(1'b1);
`ifdef NRZI_STUFF_CHECK_EN
        stuff_exp++;
        check("t3_stuff_err", stuff_err, 1);
        check("t3_rx_idle", rx_idle, 1);
        drive_raw(1'b0);
        drive_raw(1'b0);
        line = 1'b1;
        s_in = 1'b1;
        cyc();
        check("t3_no_word", out_valid, 0);
`else
        check("t3_stuff_err", stuff_err, 0);
        exp_q.push_back(8'h7F);
        drive_raw(1'b0);
        drive_raw(1'b0);
        check("t3_data", out_data, 8'h7F);
        frame_stop();
`endif

        // Two words complete while the consumer stalls
        hold_mode = 1'b1; model_held = 1'b0; out_ready = 1'b0;
        frame_start();
        send_word(8'h3C);
        send_word(8'hC3);
        frame_stop();
        cyc();
        check("t4_held_valid", out_valid, 1);
        check("t4_held_data", out_data, 8'h3C);
        hold_mode = 1'b0; model_held = 1'b0; out_ready = 1'b1;
        cyc();
        check("t4_valid_fall", out_valid, 0);
        check("t4_overrun_cnt", ovr_seen, ovr_exp);

        // Stop after 3 bits, then after exactly 16
        frame_start();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        frame_stop();
        cyc();
        check("t5_no_word", out_valid, 0);
        frame_start();
        w = WIDTH'($urandom);
        send_word(w);
        w = WIDTH'($urandom);
        send_word(w);
        frame_stop();

        // Abort mid-word with a word pending
        hold_mode = 1'b1; model_held = 1'b0; out_ready = 1'b0;
        frame_start();
        send_word(8'h5A);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        hold_mode = 1'b0;
        frame_abort();
        check("t6_rx_idle", rx_idle, 1);
        check("t6_valid_cleared", out_valid, 0);
        out_ready = 1'b1;
        frame_start();
        send_word(8'hA5);
        check("t6_data", out_data, 8'hA5);
        frame_stop();

        // Random frames, mostly-ones payloads, random stop/abort, throttled consumer
        rand_ready = 1'b1; lo_run = 0;
        for (int f = 0; f < 30; f++) begin
            int len;
            frame_start();
            len = $urandom_range(0, 40);
            for (int i = 0; i < len; i++) send_bit($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) frame_abort();
            else                          frame_stop();
            repeat ($urandom_range(0, 3)) cyc();
        end

        rand_ready = 1'b0; out_ready = 1'b1;
        repeat (5) cyc();
        check("drain_words", exp_q.size(), 0);
        check("drain_ends", end_q.size(), 0);
        check("overrun_total", ovr_seen, ovr_exp);
        check("stuff_err_total", stuff_seen, stuff_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
